// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator and its BTB.
package pc_gen_pkg;
   localparam int INSTR_BYTES = 4;

   // Kind of redirect parked while the fetch port is stalled.
   typedef enum logic [1:0] {
      PEND_NONE  = 2'd0,
      PEND_REDIR = 2'd1,
      PEND_TRAP  = 2'd2
   } pend_kind_e;
endpackage

// File: rtl/pc_gen_btb_if.sv
// Fetch-PC unit bus: control/update inputs from EX/IM and PC/prediction outputs to IF/ID.
interface pc_gen_btb_if #(parameter int XLEN = 32);
   logic            fetch_stall_i;
   logic            hazard_hold_i;
   logic            redirect_valid_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            trap_valid_i;
   logic [XLEN-1:0] trap_vec_i;
   logic            btb_upd_valid_i;
   logic [XLEN-1:0] btb_upd_pc_i;
   logic [XLEN-1:0] btb_upd_target_i;
   logic            btb_upd_taken_i;
   logic            btb_flush_i;
   logic [XLEN-1:0] pc_o;
   logic            pred_taken_o;
   logic [XLEN-1:0] pred_target_o;
   logic            redirect_pending_o;

   modport master (
      output fetch_stall_i, hazard_hold_i, redirect_valid_i, redirect_pc_i,
             trap_valid_i, trap_vec_i, btb_upd_valid_i, btb_upd_pc_i,
             btb_upd_target_i, btb_upd_taken_i, btb_flush_i,
      input  pc_o, pred_taken_o, pred_target_o, redirect_pending_o
   );

   modport slave (
      input  fetch_stall_i, hazard_hold_i, redirect_valid_i, redirect_pc_i,
             trap_valid_i, trap_vec_i, btb_upd_valid_i, btb_upd_pc_i,
             btb_upd_target_i, btb_upd_taken_i, btb_flush_i,
      output pc_o, pred_taken_o, pred_target_o, redirect_pending_o
   );
endinterface

// File: rtl/pc_gen_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update/flush.
// PCs and targets arrive word-aligned (bits [1:0] already stripped).
module btb_dm #(
   parameter int XLEN      = 32,
   parameter int BTB_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-3:0] lookup_pc,
   output logic            hit,
   output logic [XLEN-1:0] target,
   input  logic            upd_valid,
   input  logic [XLEN-3:0] upd_pc,
   input  logic [XLEN-3:0] upd_target,
   input  logic            upd_taken,
   input  logic            flush
);
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-3:0]  target;
   } btb_entry_t;

   btb_entry_t mem [BTB_DEPTH];

   logic [IDX_W-1:0] l_idx, u_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   btb_entry_t       l_ent;

   assign l_idx = lookup_pc[IDX_W-1:0];
   assign l_tag = lookup_pc[XLEN-3:IDX_W];
   assign u_idx = upd_pc[IDX_W-1:0];
   assign u_tag = upd_pc[XLEN-3:IDX_W];

   assign l_ent  = mem[l_idx];
   assign hit    = l_ent.valid && (l_ent.tag == l_tag);
   assign target = hit ? {l_ent.target, 2'b00} : '0;

   // Flush wins over a same-cycle update; a not-taken update only evicts its own tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < BTB_DEPTH; i++) mem[i].valid <= 1'b0;
      end else if (upd_valid) begin
         if (upd_taken)
            mem[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target};
         else if (mem[u_idx].tag == u_tag)
            mem[u_idx].valid <= 1'b0;
      end
   end
endmodule

// File: rtl/pc_gen_btb.sv
// Fetch PC generator: PC register, stall-safe pending redirect and next-PC priority mux
// with BTB-directed prediction.
module pc_gen_btb
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              BTB_DEPTH = 16
) (
   input logic        clk,
   input logic        rst,
   pc_gen_btb_if.slave bus
);
   logic [XLEN-3:0] pc_q, pc_d;
   logic [XLEN-3:0] pend_pc_q, pend_pc_d;
   pend_kind_e      pend_kind_q, pend_kind_d;
   logic            btb_hit;
   logic [XLEN-1:0] btb_target;
   logic [XLEN-1:0] pc_seq;
   logic            unused_low_bits;

   assign bus.pc_o               = {pc_q, 2'b00};
   assign bus.pred_taken_o       = btb_hit;
   assign bus.pred_target_o      = btb_target;
   assign bus.redirect_pending_o = (pend_kind_q != PEND_NONE);
   assign pc_seq                 = bus.pc_o + XLEN'(INSTR_BYTES);

   // Incoming targets are word-aligned by dropping bits [1:0].
   assign unused_low_bits = ^{bus.redirect_pc_i[1:0], bus.trap_vec_i[1:0],
                              bus.btb_upd_pc_i[1:0], bus.btb_upd_target_i[1:0],
                              btb_target[1:0], pc_seq[1:0]};

   btb_dm #(.XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH)) u_btb (
      .clk        (clk),
      .rst        (rst),
      .lookup_pc  (pc_q),
      .hit        (btb_hit),
      .target     (btb_target),
      .upd_valid  (bus.btb_upd_valid_i),
      .upd_pc     (bus.btb_upd_pc_i[XLEN-1:2]),
      .upd_target (bus.btb_upd_target_i[XLEN-1:2]),
      .upd_taken  (bus.btb_upd_taken_i),
      .flush      (bus.btb_flush_i)
   );

   always_comb begin
      pc_d        = pc_q;
      pend_pc_d   = pend_pc_q;
      pend_kind_d = pend_kind_q;
      if (bus.fetch_stall_i) begin
         // A parked trap is never displaced by a later redirect.
         if (bus.trap_valid_i) begin
            pend_kind_d = PEND_TRAP;
            pend_pc_d   = bus.trap_vec_i[XLEN-1:2];
         end else if (bus.redirect_valid_i && pend_kind_q != PEND_TRAP) begin
            pend_kind_d = PEND_REDIR;
            pend_pc_d   = bus.redirect_pc_i[XLEN-1:2];
         end
      end else begin
         pend_kind_d = PEND_NONE;
         if (bus.trap_valid_i)              pc_d = bus.trap_vec_i[XLEN-1:2];
         else if (bus.redirect_valid_i)     pc_d = bus.redirect_pc_i[XLEN-1:2];
         else if (pend_kind_q != PEND_NONE) pc_d = pend_pc_q;
         else if (bus.hazard_hold_i)        pc_d = pc_q;
         else if (btb_hit)                  pc_d = btb_target[XLEN-1:2];
         else                               pc_d = pc_seq[XLEN-1:2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_VEC[XLEN-1:2];
         pend_pc_q   <= '0;
         pend_kind_q <= PEND_NONE;
      end else begin
         pc_q        <= pc_d;
         pend_pc_q   <= pend_pc_d;
         pend_kind_q <= pend_kind_d;
      end
   end
endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed bench for pc_gen_btb: vector table for per-cycle behaviour plus a
// hand-written async reset sequence on two instances with different reset vectors.
module tb_pc_gen_btb;
   import pc_gen_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_rv = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pc_gen_btb_if #(.XLEN(32)) b ();
   pc_gen_btb_if #(.XLEN(32)) b2 ();

   pc_gen_btb #(.XLEN(32), .RESET_VEC(32'h0000_0000), .BTB_DEPTH(16)) dut (
      .clk (clk), .rst (rst), .bus (b)
   );
   pc_gen_btb #(.XLEN(32), .RESET_VEC(32'h0000_1000), .BTB_DEPTH(16)) dut_rv (
      .clk (clk), .rst (rst_rv), .bus (b2)
   );

   assign b2.fetch_stall_i    = 1'b0;
   assign b2.hazard_hold_i    = 1'b0;
   assign b2.redirect_valid_i = 1'b0;
   assign b2.redirect_pc_i    = '0;
   assign b2.trap_valid_i     = 1'b0;
   assign b2.trap_vec_i       = '0;
   assign b2.btb_upd_valid_i  = 1'b0;
   assign b2.btb_upd_pc_i     = '0;
   assign b2.btb_upd_target_i = '0;
   assign b2.btb_upd_taken_i  = 1'b0;
   assign b2.btb_flush_i      = 1'b0;

   typedef struct {
      logic        s, h, r;
      logic [31:0] rpc;
      logic        t;
      logic [31:0] tv;
      logic        uv;
      logic [31:0] upc, ut;
      logic        utk, f;
      logic [31:0] epc;
      logic        etk;
      logic [31:0] etgt;
      logic        epend;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s, logic h, logic r, logic [31:0] rpc,
                               logic t, logic [31:0] tv, logic uv, logic [31:0] upc,
                               logic [31:0] ut, logic utk, logic f,
                               logic [31:0] epc, logic etk, logic [31:0] etgt, logic epend);
      vec_t v;
      v.s = s; v.h = h; v.r = r; v.rpc = rpc; v.t = t; v.tv = tv;
      v.uv = uv; v.upc = upc; v.ut = ut; v.utk = utk; v.f = f;
      v.epc = epc; v.etk = etk; v.etgt = etgt; v.epend = epend;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      b.fetch_stall_i    = v.s;
      b.hazard_hold_i    = v.h;
      b.redirect_valid_i = v.r;
      b.redirect_pc_i    = v.rpc;
      b.trap_valid_i     = v.t;
      b.trap_vec_i       = v.tv;
      b.btb_upd_valid_i  = v.uv;
      b.btb_upd_pc_i     = v.upc;
      b.btb_upd_target_i = v.ut;
      b.btb_upd_taken_i  = v.utk;
      b.btb_flush_i      = v.f;
   endtask

   initial begin
      vec_t idle;
      idle = mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0);
      drive(idle);

      //         s h r rpc           t tv     uv upc    ut     tk f   epc           tk tgt     pend
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h4,        0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h8,        0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'hC,        0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h10,       0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  1,32'h10,32'h400,1,0, 32'h14,       0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'h10,    0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h10,       1,32'h400, 0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h400,      0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'h10,    0,32'h0,  1,32'h10,32'h0,  0,0, 32'h10,       0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h14,       0,32'h0,   0));
      vecs.push_back(mk(1,0,1,32'h200,   0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h14,       0,32'h0,   1));
      vecs.push_back(mk(1,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h14,       0,32'h0,   1));
      vecs.push_back(mk(1,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h14,       0,32'h0,   1));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h200,      0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h204,      0,32'h0,   0));
      vecs.push_back(mk(1,0,0,32'h0,     1,32'h80, 0,32'h0, 32'h0,  0,0, 32'h204,      0,32'h0,   1));
      vecs.push_back(mk(1,0,1,32'h300,   0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h204,      0,32'h0,   1));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h80,       0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h84,       0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'h300,   1,32'h80, 0,32'h0, 32'h0,  0,0, 32'h80,       0,32'h0,   0));
      vecs.push_back(mk(0,1,1,32'h40,    0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h40,       0,32'h0,   0));
      vecs.push_back(mk(0,1,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h40,       0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'h47,    0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h44,       0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'h10,    0,32'h0,  1,32'h10,32'h400,1,0, 32'h10,       1,32'h400, 0));
      vecs.push_back(mk(0,0,1,32'h10,    0,32'h0,  1,32'h50,32'h600,1,0, 32'h10,       0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'h50,    0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h50,       1,32'h600, 0));
      vecs.push_back(mk(0,1,0,32'h0,     0,32'h0,  1,32'h50,32'h700,1,1, 32'h50,       0,32'h0,   0));
      vecs.push_back(mk(1,0,0,32'h0,     0,32'h0,  1,32'h50,32'h500,1,0, 32'h50,       1,32'h500, 0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h500,      0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'h50,    0,32'h0,  1,32'h90,32'h0,  0,0, 32'h50,       1,32'h500, 0));
      vecs.push_back(mk(1,0,1,32'h100,   0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h50,       1,32'h500, 1));
      vecs.push_back(mk(1,0,1,32'h180,   0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h50,       1,32'h500, 1));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h180,      0,32'h0,   0));
      vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,0,32'h0,0,32'h0,32'h0,  0,0, 32'hFFFF_FFFC, 0,32'h0,   0));
      vecs.push_back(mk(0,0,0,32'h0,     0,32'h0,  0,32'h0, 32'h0,  0,0, 32'h0,        0,32'h0,   0));

      // Reset state on both instances.
      #12;
      chk("reset pc", b.pc_o, 32'h0);
      chk("reset pred_taken", {31'b0, b.pred_taken_o}, 32'h0);
      chk("reset pred_target", b.pred_target_o, 32'h0);
      chk("reset pending", {31'b0, b.redirect_pending_o}, 32'h0);
      chk("reset pc rv", b2.pc_o, 32'h1000);
      @(negedge clk);
      rst = 1'b0;
      rst_rv = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d pc", i), b.pc_o, vecs[i].epc);
         chk($sformatf("v%0d pred_taken", i), {31'b0, b.pred_taken_o}, {31'b0, vecs[i].etk});
         chk($sformatf("v%0d pred_target", i), b.pred_target_o, vecs[i].etgt);
         chk($sformatf("v%0d pending", i), {31'b0, b.redirect_pending_o}, {31'b0, vecs[i].epend});
         @(negedge clk);
      end

      // Async reset mid-stall discards a parked redirect and restores each reset vector.
      drive(idle);
      @(posedge clk); #1;
      chk("pre-reset pc", b.pc_o, 32'h4);
      @(negedge clk);
      b.fetch_stall_i = 1'b1; b.redirect_valid_i = 1'b1; b.redirect_pc_i = 32'h300;
      @(posedge clk); #1;
      chk("pre-reset pending", {31'b0, b.redirect_pending_o}, 32'h1);
      #2;
      rst = 1'b1; rst_rv = 1'b1;
      #1;
      chk("async reset pc", b.pc_o, 32'h0);
      chk("async reset pending", {31'b0, b.redirect_pending_o}, 32'h0);
      chk("async reset pc rv", b2.pc_o, 32'h1000);
      @(negedge clk);
      drive(idle);
      rst = 1'b0; rst_rv = 1'b0;
      @(posedge clk); #1;
      chk("post-reset pc", b.pc_o, 32'h4);
      chk("post-reset pc rv", b2.pc_o, 32'h1004);
      // BTB contents must be gone after reset: 0x50 was trained to 0x500.
      @(negedge clk);
      b.redirect_valid_i = 1'b1; b.redirect_pc_i = 32'h50;
      @(posedge clk); #1;
      chk("post-reset btb miss", {31'b0, b.pred_taken_o}, 32'h0);
      chk("post-reset btb target", b.pred_target_o, 32'h0);
      @(negedge clk);
      drive(idle);
      @(posedge clk); #1;
      chk("post-reset seq", b.pc_o, 32'h54);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
